// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline has priority, and LLU results are buffered in a FIFO.
// Starved LLU results force a one-cycle pipeline stall, and WAW hazards squash older LLU writes.
module wb_port_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we_i,
  input  logic [ADDR_W-1:0] pipe_waddr_i,
  input  logic [DATA_W-1:0] pipe_wdata_i,
  output logic              pipe_stall_o,
  input  logic              llu_valid_i,
  input  logic [ADDR_W-1:0] llu_waddr_i,
  input  logic [DATA_W-1:0] llu_wdata_i,
  output logic              llu_ready_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              llu_pending_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic              fifo_live [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] starve_cnt;

  logic fifo_empty, head_live, head_dead;
  logic pipe_req, grant_pipe, grant_fifo;
  logic pop, push, push_live;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty    = (occ == '0);
  assign llu_ready_o   = (occ < OCC_W'(FIFO_DEPTH));
  assign llu_pending_o = !fifo_empty;
  assign head_live     = !fifo_empty && fifo_live[rd_ptr];
  assign head_dead     = !fifo_empty && !fifo_live[rd_ptr];
  assign pipe_stall_o  = head_live && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // A zero destination is consumed silently, which leaves the port free for the FIFO head.
  assign pipe_req   = pipe_we_i && (pipe_waddr_i != '0);
  assign grant_pipe = pipe_req && !pipe_stall_o;
  assign grant_fifo = head_live && !grant_pipe;

  // A dead head is retired without using the port.
  assign pop       = grant_fifo || head_dead;
  assign push      = llu_valid_i && llu_ready_o && (llu_waddr_i != '0);
  assign push_live = !(grant_pipe && (llu_waddr_i == pipe_waddr_i));

  // NOTE: FIFO storage has no reset; occupancy alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (grant_pipe && (fifo_addr[i] == pipe_waddr_i)) fifo_live[i] <= 1'b0;
    end
    if (push) begin
      fifo_live[wr_ptr] <= push_live;
      fifo_addr[wr_ptr] <= llu_waddr_i;
      fifo_data[wr_ptr] <= llu_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      starve_cnt <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      if (pop || fifo_empty)
        starve_cnt <= '0;
      else if (grant_pipe && (starve_cnt != CNT_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;

      // Address and data are held when no write is granted.
      if (grant_pipe) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= pipe_waddr_i;
        rf_wdata_o <= pipe_wdata_i;
      end else if (grant_fifo) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= fifo_addr[rd_ptr];
        rf_wdata_o <= fifo_data[rd_ptr];
      end else begin
        rf_we_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: the stimulus queues the expected writes in order,
// and a negedge monitor checks every rf write against that queue.
module tb_wb_port_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_we_i;
  logic [ADDR_W-1:0] pipe_waddr_i;
  logic [DATA_W-1:0] pipe_wdata_i;
  logic              pipe_stall_o;
  logic              llu_valid_i;
  logic [ADDR_W-1:0] llu_waddr_i;
  logic [DATA_W-1:0] llu_wdata_i;
  logic              llu_ready_o;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;
  logic              llu_pending_o;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
    .pipe_stall_o(pipe_stall_o),
    .llu_valid_i(llu_valid_i), .llu_waddr_i(llu_waddr_i), .llu_wdata_i(llu_wdata_i),
    .llu_ready_o(llu_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .llu_pending_o(llu_pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_q [$];
  wr_t               mon_e;
  logic [DATA_W-1:0] shadow_rf [32];
  int                n_cmp = 0;
  int                n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pipe_we_i    = we;
    pipe_waddr_i = a;
    pipe_wdata_i = d;
  endtask

  task automatic drive_llu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    llu_valid_i = v;
    llu_waddr_i = a;
    llu_wdata_i = d;
  endtask

  // Scoreboard monitor: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && rf_we_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write (t=%0t)",
                 rf_waddr_o, rf_wdata_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(rf_waddr_o), 64'(mon_e.addr));
        check("wr_data", rf_wdata_o, mon_e.data);
      end
      shadow_rf[rf_waddr_o] = rf_wdata_o;
    end
  end

  logic [DATA_W-1:0] st_data  [7];
  logic              st_stall [7];
  logic [DATA_W-1:0] bp_data  [7];
  logic              bp_ready [7];
  logic              bp_stall [7];
  wr_t               bp_llu   [3];
  int                li;

  initial begin
    rst = 1'b1;
    drive_pipe(1'b0, '0, '0);
    drive_llu(1'b0, '0, '0);
    #1 rst = 1'b0;
    #1;
    check("rst_rf_we",    64'(rf_we_o), 64'h0);
    check("rst_rf_waddr", 64'(rf_waddr_o), 64'h0);
    check("rst_rf_wdata", rf_wdata_o, 64'h0);
    check("rst_stall",    64'(pipe_stall_o), 64'h0);
    check("rst_ready",    64'(llu_ready_o), 64'h1);
    check("rst_pending",  64'(llu_pending_o), 64'h0);
    step();
    step();
    rst = 1'b1;

    // Idle after reset release: the monitor flags any write.
    repeat (3) step();
    check("idle_no_write", 64'(rf_we_o), 64'h0);

    // Pipeline write, then a zero-address request that must not write.
    expect_wr(5'd5, 64'hDEAD_BEEF);
    drive_pipe(1'b1, 5'd5, 64'hDEAD_BEEF);
    step();
    drive_pipe(1'b0, '0, '0);
    step();
    check("pipe_we_drops", 64'(rf_we_o), 64'h0);
    drive_pipe(1'b1, 5'd0, 64'h5555);
    step();
    drive_pipe(1'b0, '0, '0);
    step();
    check("zero_addr_no_write", 64'(rf_we_o), 64'h0);
    check("zero_addr_holds_waddr", 64'(rf_waddr_o), 64'h5);

    // LLU result into an idle port.
    expect_wr(5'd7, 64'h1234);
    drive_llu(1'b1, 5'd7, 64'h1234);
    check("llu_idle_ready", 64'(llu_ready_o), 64'h1);
    step();
    drive_llu(1'b0, '0, '0);
    check("llu_idle_pending_n1", 64'(llu_pending_o), 64'h1);
    step();
    check("llu_idle_pending_n2", 64'(llu_pending_o), 64'h0);
    step();
    check("llu_idle_we_drops", 64'(rf_we_o), 64'h0);

    // Starvation: one live entry behind a pipeline that writes addr 3 every cycle.
    st_data  = '{64'h30, 64'h31, 64'h32, 64'h33, 64'h34, 64'h35, 64'h35};
    st_stall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    expect_wr(5'd3, 64'h30);
    expect_wr(5'd3, 64'h31);
    expect_wr(5'd3, 64'h32);
    expect_wr(5'd3, 64'h33);
    expect_wr(5'd3, 64'h34);
    expect_wr(5'd9, 64'h99);
    expect_wr(5'd3, 64'h35);
    for (int i = 0; i < 7; i++) begin
      drive_pipe(1'b1, 5'd3, st_data[i]);
      if (i == 0) drive_llu(1'b1, 5'd9, 64'h99);
      else        drive_llu(1'b0, '0, '0);
      check($sformatf("starve_stall_c%0d", i), 64'(pipe_stall_o), 64'(st_stall[i]));
      step();
    end
    drive_pipe(1'b0, '0, '0);
    repeat (2) step();
    check("starve_drained", 64'(llu_pending_o), 64'h0);

    // WAW squash: the queued entry and a same-cycle push to addr 12 both die.
    expect_wr(5'd1, 64'h11);
    expect_wr(5'd12, 64'hBBBB);
    drive_pipe(1'b1, 5'd1, 64'h11);
    drive_llu(1'b1, 5'd12, 64'hAAAA);
    step();
    drive_pipe(1'b1, 5'd12, 64'hBBBB);
    drive_llu(1'b1, 5'd12, 64'hCCCC);
    check("waw_ready", 64'(llu_ready_o), 64'h1);
    check("waw_no_stall", 64'(pipe_stall_o), 64'h0);
    step();
    drive_pipe(1'b0, '0, '0);
    drive_llu(1'b0, '0, '0);
    check("waw_pending_c2", 64'(llu_pending_o), 64'h1);
    step();
    check("waw_pending_c3", 64'(llu_pending_o), 64'h1);
    check("waw_dead_pop_no_write", 64'(rf_we_o), 64'h0);
    step();
    check("waw_pending_c4", 64'(llu_pending_o), 64'h0);
    check("waw_dead_pop2_no_write", 64'(rf_we_o), 64'h0);
    check("waw_final_reg12", shadow_rf[12], 64'hBBBB);

    // Full FIFO backpressure: the third result waits for the first forced drain.
    bp_data  = '{64'h200, 64'h201, 64'h202, 64'h203, 64'h204, 64'h205, 64'h205};
    bp_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bp_stall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bp_llu[0].addr = 5'd20; bp_llu[0].data = 64'hA0;
    bp_llu[1].addr = 5'd21; bp_llu[1].data = 64'hB0;
    bp_llu[2].addr = 5'd22; bp_llu[2].data = 64'hC0;
    for (int i = 0; i < 5; i++) expect_wr(5'd2, bp_data[i]);
    expect_wr(5'd20, 64'hA0);
    expect_wr(5'd2, 64'h205);
    expect_wr(5'd21, 64'hB0);
    expect_wr(5'd22, 64'hC0);
    li = 0;
    for (int i = 0; i < 7; i++) begin
      drive_pipe(1'b1, 5'd2, bp_data[i]);
      if (li < 3) drive_llu(1'b1, bp_llu[li].addr, bp_llu[li].data);
      else        drive_llu(1'b0, '0, '0);
      check($sformatf("bp_ready_c%0d", i), 64'(llu_ready_o), 64'(bp_ready[i]));
      check($sformatf("bp_stall_c%0d", i), 64'(pipe_stall_o), 64'(bp_stall[i]));
      if (llu_valid_i && llu_ready_o) li++;
      step();
    end
    drive_pipe(1'b0, '0, '0);
    drive_llu(1'b0, '0, '0);
    check("bp_all_accepted", 64'(li), 64'h3);
    repeat (4) step();
    check("bp_drained", 64'(llu_pending_o), 64'h0);

    // Asynchronous reset with two entries queued and a write on the port.
    expect_wr(5'd4, 64'h44);
    drive_pipe(1'b1, 5'd4, 64'h44);
    drive_llu(1'b1, 5'd25, 64'h250);
    step();
    drive_pipe(1'b1, 5'd4, 64'h45);
    drive_llu(1'b1, 5'd26, 64'h260);
    step();
    drive_pipe(1'b0, '0, '0);
    drive_llu(1'b0, '0, '0);
    check("prerst_pending", 64'(llu_pending_o), 64'h1);
    check("prerst_ready", 64'(llu_ready_o), 64'h0);
    check("prerst_we", 64'(rf_we_o), 64'h1);
    #1 rst = 1'b0;
    #1;
    check("midrst_rf_we", 64'(rf_we_o), 64'h0);
    check("midrst_rf_waddr", 64'(rf_waddr_o), 64'h0);
    check("midrst_rf_wdata", rf_wdata_o, 64'h0);
    check("midrst_pending", 64'(llu_pending_o), 64'h0);
    check("midrst_ready", 64'(llu_ready_o), 64'h1);
    check("midrst_stall", 64'(pipe_stall_o), 64'h0);
    step();
    step();
    rst = 1'b1;
    repeat (4) step();
    check("postrst_no_write", 64'(rf_we_o), 64'h0);
    check("postrst_pending", 64'(llu_pending_o), 64'h0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order pipeline's MEM/WB stage;
  - a long-latency unit (LLU: mul/div, late loads) that returns results out of band.
- Buffers LLU results in a small FIFO and gives the pipeline priority.
- Enforces write-after-write ordering.
- Stalls the pipeline for one cycle when a buffered LLU result has waited too long.

Parameters:
- DATA_W, 64, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, LLU result buffer entries (>=1)
- STARVE_LIMIT, 4, consecutive lost arbitrations before a forced LLU grant (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- pipe_we_i  in  1  pipeline write request (MEM/WB write enable)
- pipe_waddr_i  in  ADDR_W  pipeline destination register
- pipe_wdata_i  in  DATA_W  pipeline write data
- pipe_stall_o  out  1  pipeline must hold MEM/WB contents this cycle
- llu_valid_i  in  1  LLU result valid
- llu_waddr_i  in  ADDR_W  LLU destination register
- llu_wdata_i  in  DATA_W  LLU result
- llu_ready_o  out  1  arbiter accepts LLU result this cycle
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  ADDR_W  register-file write address
- rf_wdata_o  out  DATA_W  register-file write data
- llu_pending_o  out  1  FIFO holds at least one entry (live or dead)

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - FIFO emptied; starvation counter=0.
  - pipe_stall_o=0, llu_ready_o=1, llu_pending_o=0.
- Reset mid-operation: all buffered LLU results are lost. There is no partial write; the outputs are cleared immediately.
- FIFO entry fields: {live, addr, data}. Occupancy counts both live and dead entries.
- Combinational outputs from registered state:
  - llu_ready_o = (occupancy < FIFO_DEPTH); no same-cycle pop-through.
  - pipe_stall_o = head live AND starve_cnt == STARVE_LIMIT.
  - llu_pending_o = occupancy != 0.
- Per-cycle grant, in priority order:
  1. pipe_stall_o=1: grant the FIFO head. The pipeline request is ignored and the stage repeats it next cycle.
  2. pipe_we_i=1 and pipe_waddr_i!=0: grant the pipeline.
  3. FIFO head live: grant the FIFO head.
  4. Otherwise: no write.
- A pipeline request with pipe_waddr_i==0 is consumed without a write; the port is then free for the FIFO.
- Dead head: popped in the same cycle without using the port. A live entry behind it cannot be granted until the next cycle.
- Write latency: the granted write appears on rf_*_o after the next clk edge and is held for exactly one cycle.
  - rf_we_o=0 in cycles with no grant.
  - rf_waddr_o/rf_wdata_o keep their last values when rf_we_o=0.
- LLU push:
  - Occurs when llu_valid_i && llu_ready_o.
  - llu_waddr_i==0: accepted and discarded, not pushed.
  - Otherwise pushed at the tail with live=1.
- WAW squash: when the pipeline is granted with address A≠0, the following are marked dead in that same cycle:
  - every FIFO entry with addr==A;
  - a same-cycle LLU push with llu_waddr_i==A.
  - Rationale: the pipeline writer is always treated as the younger instruction.
- Simultaneous events:
  - Pop and push in the same cycle is legal. Occupancy is unchanged.
  - A push arriving while the FIFO is full is not accepted. The LLU holds its data until llu_ready_o=1.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when the head is live and the pipeline is granted.
  - Clears on any FIFO grant, dead-head pop, or empty FIFO.
- Squash never stalls the pipeline.
- FIFO pointers wrap modulo FIFO_DEPTH. Full means occupancy==FIFO_DEPTH. Empty means occupancy==0.

Test Plan:
- Reset:
  - Drive rst=0 mid-stream with 2 LLU entries queued: rf_we_o=0, llu_pending_o=0 and llu_ready_o=1 immediately, without waiting for a clk edge.
  - After release, with no requests: no writes.
- Pipeline only:
  - pipe_we_i=1, addr=5, data=0xDEAD_BEEF at cycle N: rf_we_o=1, addr=5, data=0xDEAD_BEEF in cycle N+1; rf_we_o=0 in N+2.
  - addr=0: no write.
- LLU into idle port:
  - llu_valid_i, addr=7, data=0x1234 with the pipeline idle: pushed at N, head granted at N+1, rf write addr=7 visible at N+2.
  - llu_pending_o=1 during N+1 only.
- Starvation (STARVE_LIMIT=4):
  - One live LLU entry (addr=9); the pipeline writes addr=3 every cycle.
  - Four pipeline writes complete, then pipe_stall_o=1 for exactly one cycle.
  - The next rf write is addr=9, followed by the held pipeline write addr=3.
- WAW squash:
  - FIFO holds addr=12 (data 0xAAAA); the pipeline writes addr=12 (data 0xBBBB).
  - Only 0xBBBB is written. The dead entry is popped with no rf write, and the register ends at 0xBBBB.
- Full / backpressure (FIFO_DEPTH=2):
  - Three back-to-back LLU results with the pipeline writing every cycle: llu_ready_o=0 after 2 pushes.
  - The third result is accepted only in the cycle after the first forced drain.
  - Results are written in order.
